// File: rtl/event_encoder8_pkg.sv
// Shared types and helpers for the 8-to-3 event encoder.
package encoder_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One-hot grant vector for a given code.
  function automatic logic [N-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [N-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational rotating priority encoder: searches pending downward from
// start, wrapping 0 -> 7. start = 3'b111 gives plain highest-index priority.
module prio_enc8
  import encoder_pkg::*;
(
  input  logic [N-1:0]      pending,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] sel,
  output logic              any
);

  logic              found;
  logic [CODE_W-1:0] idx;

  // First set bit at or below start, modulo N.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = start - CODE_W'(k);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    any = |pending;
  end

endmodule

// File: rtl/event_encoder8.sv
// Sequential 8-to-3 event encoder: sticky pending register drained one code
// per VALID/READY handshake. Define EVENT_ENCODER8_ROUND_ROBIN_EN for
// rotating priority; otherwise highest index wins.
module event_encoder8
  import encoder_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [N-1:0]      REQ_IN,
  input  logic              READY_IN,
  output logic [CODE_W-1:0] CODE_OUT,
  output logic              VALID_OUT,
  output logic [N-1:0]      PENDING_OUT,
  output logic              OVERFLOW_OUT,
  input  logic              CLR_OVF
);

  state_t            state_q, state_d;
  logic [N-1:0]      pending_q, pending_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [N-1:0]      grant;
  logic              load;
  logic [CODE_W-1:0] sel;
  logic              any;
  logic [CODE_W-1:0] start;

`ifdef EVENT_ENCODER8_ROUND_ROBIN_EN
  logic [CODE_W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '1;
`endif

  prio_enc8 u_prio (
    .pending (pending_q),
    .start   (start),
    .sel     (sel),
    .any     (any)
  );

  // Handshake FSM, grant generation, pending and overflow next-state.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    load    = 1'b0;
    grant   = '0;
    unique case (state_q)
      IDLE: begin
        if (any) load = 1'b1;
      end
      HOLD: begin
        if (READY_IN) begin
          if (any) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (load) begin
      grant   = onehot_of(sel);
      code_d  = sel;
      valid_d = 1'b1;
      state_d = HOLD;
    end
    // A request landing on its own grant edge re-arms the bit: no loss.
    pending_d = (pending_q & ~grant) | REQ_IN;
    // A new overflow beats a same-cycle clear.
    ovf_d     = (ovf_q & ~CLR_OVF) | (|(REQ_IN & pending_q & ~grant));
  end

`ifdef EVENT_ENCODER8_ROUND_ROBIN_EN
  // Pointer moves to just below the granted code, only on load edges.
  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = sel - CODE_W'(1);
  end

  // Rotating-priority pointer register.
  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= '1;
    else     ptr_q <= ptr_d;
  end
`endif

  // State registers; reset drops any held code and all pending events.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign CODE_OUT     = code_q;
  assign VALID_OUT    = valid_q;
  assign PENDING_OUT  = pending_q;
  assign OVERFLOW_OUT = ovf_q;

endmodule

// File: tb/tb_event_encoder8.sv
// Directed bench for event_encoder8: cycle table plus drain sequences.
module tb_event_encoder8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] REQ_IN;
  logic       READY_IN;
  logic [2:0] CODE_OUT;
  logic       VALID_OUT;
  logic [7:0] PENDING_OUT;
  logic       OVERFLOW_OUT;
  logic       CLR_OVF;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  event_encoder8 dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_IN       (REQ_IN),
    .READY_IN     (READY_IN),
    .CODE_OUT     (CODE_OUT),
    .VALID_OUT    (VALID_OUT),
    .PENDING_OUT  (PENDING_OUT),
    .OVERFLOW_OUT (OVERFLOW_OUT),
    .CLR_OVF      (CLR_OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic       clr;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  localparam int unsigned NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic [7:0] req, input logic ready,
                              input logic clr, input logic [2:0] code, input logic valid,
                              input logic [7:0] pend, input logic ovf);
    vec_t v;
    v.rst = rst; v.req = req; v.ready = ready; v.clr = clr;
    v.code = code; v.valid = valid; v.pend = pend; v.ovf = ovf;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [7:0] req, input logic ready, input logic clr);
    RST = rst; REQ_IN = req; READY_IN = ready; CLR_OVF = clr;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got code=%0d valid=%0b pend=%02h ovf=%0b, want code=%0d valid=%0b pend=%02h ovf=%0b",
               name, act[12:10], act[9], act[8:1], act[0], exp[12:10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  function automatic logic [12:0] outs();
    return {CODE_OUT, VALID_OUT, PENDING_OUT, OVERFLOW_OUT};
  endfunction

  logic [2:0] exp_seq [5];

  initial begin
    // rst req ready clr | code valid pend ovf (after the edge)
    tbl[0]  = mk(1, 8'hFF, 0, 1, 3'd0, 0, 8'h00, 0); // reset ignores REQ/CLR
    tbl[1]  = mk(0, 8'h20, 1, 0, 3'd0, 0, 8'h20, 0); // single event captured
    tbl[2]  = mk(0, 8'h00, 1, 0, 3'd5, 1, 8'h00, 0); // valid two edges after pulse
    tbl[3]  = mk(0, 8'h00, 1, 0, 3'd5, 0, 8'h00, 0); // accepted, back to idle
    tbl[4]  = mk(0, 8'h81, 0, 0, 3'd5, 0, 8'h81, 0); // backpressure
    tbl[5]  = mk(0, 8'h00, 0, 0, 3'd7, 1, 8'h01, 0);
    tbl[6]  = mk(0, 8'h00, 0, 0, 3'd7, 1, 8'h01, 0);
    tbl[7]  = mk(0, 8'h00, 0, 0, 3'd7, 1, 8'h01, 0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 3'd7, 1, 8'h01, 0);
    tbl[9]  = mk(0, 8'h00, 1, 0, 3'd0, 1, 8'h00, 0); // back-to-back code 0
    tbl[10] = mk(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);
    tbl[11] = mk(0, 8'h04, 0, 0, 3'd0, 0, 8'h04, 0); // overflow setup
    tbl[12] = mk(0, 8'h00, 0, 0, 3'd2, 1, 8'h00, 0);
    tbl[13] = mk(0, 8'h04, 0, 0, 3'd2, 1, 8'h04, 0);
    tbl[14] = mk(0, 8'h00, 0, 0, 3'd2, 1, 8'h04, 0);
    tbl[15] = mk(0, 8'h00, 0, 0, 3'd2, 1, 8'h04, 0);
    tbl[16] = mk(0, 8'h04, 0, 0, 3'd2, 1, 8'h04, 1); // event lost
    tbl[17] = mk(0, 8'h00, 0, 1, 3'd2, 1, 8'h04, 0); // clear
    tbl[18] = mk(0, 8'h04, 0, 1, 3'd2, 1, 8'h04, 1); // overflow beats clear
    tbl[19] = mk(0, 8'h00, 0, 1, 3'd2, 1, 8'h04, 0);
    tbl[20] = mk(0, 8'h00, 1, 0, 3'd2, 1, 8'h00, 0);
    tbl[21] = mk(0, 8'h00, 1, 0, 3'd2, 0, 8'h00, 0);
    tbl[22] = mk(0, 8'h08, 1, 0, 3'd2, 0, 8'h08, 0); // simultaneous grant+req
    tbl[23] = mk(0, 8'h08, 1, 0, 3'd3, 1, 8'h08, 0);
    tbl[24] = mk(0, 8'h00, 1, 0, 3'd3, 1, 8'h00, 0);
    tbl[25] = mk(0, 8'h00, 1, 0, 3'd3, 0, 8'h00, 0);
    tbl[26] = mk(0, 8'h10, 0, 0, 3'd3, 0, 8'h10, 0); // mid-handshake reset
    tbl[27] = mk(0, 8'h00, 0, 0, 3'd4, 1, 8'h00, 0);
    tbl[28] = mk(1, 8'h01, 0, 0, 3'd0, 0, 8'h00, 0);
    tbl[29] = mk(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 0);

    drive(1, '0, 0, 0);
    step();
    for (int i = 0; i < int'(NV); i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].ready, tbl[i].clr);
      step();
      check($sformatf("vec%0d", i), outs(), {tbl[i].code, tbl[i].valid, tbl[i].pend, tbl[i].ovf});
    end

    // All-ones pending drains 7..0, one per cycle.
    drive(0, 8'hFF, 1, 0);
    step();
    check("drain_fill", outs(), {3'd0, 1'b0, 8'hFF, 1'b0});
    drive(0, 8'h00, 1, 0);
    for (int k = 7; k >= 0; k--) begin
      logic [7:0] rem;
      rem = 8'hFF >> (8 - k);
      step();
      check($sformatf("drain_code%0d", k), outs(), {3'(k), 1'b1, rem, 1'b0});
    end
    step();
    check("drain_idle", outs(), {3'd0, 1'b0, 8'h00, 1'b0});

    // Inject bit 7 after code 4 is shown, with a fresh reset for the pointer.
    drive(1, 8'h00, 0, 0);
    step();
    drive(0, 8'hFF, 1, 0);
    step();
    drive(0, 8'h00, 1, 0);
    for (int k = 7; k >= 4; k--) begin
      step();
      n_tests++;
      if (CODE_OUT !== 3'(k) || VALID_OUT !== 1'b1) begin
        n_fail++;
        $display("FAIL inj_pre%0d: got code=%0d valid=%0b, want code=%0d valid=1", k, CODE_OUT, VALID_OUT, k);
      end
    end
`ifdef EVENT_ENCODER8_ROUND_ROBIN_EN
    exp_seq[0] = 3'd3; exp_seq[1] = 3'd2; exp_seq[2] = 3'd1; exp_seq[3] = 3'd0; exp_seq[4] = 3'd7;
`else
    exp_seq[0] = 3'd3; exp_seq[1] = 3'd7; exp_seq[2] = 3'd2; exp_seq[3] = 3'd1; exp_seq[4] = 3'd0;
`endif
    drive(0, 8'h80, 1, 0);
    for (int j = 0; j < 5; j++) begin
      step();
      drive(0, 8'h00, 1, 0);
      n_tests++;
      if (CODE_OUT !== exp_seq[j] || VALID_OUT !== 1'b1) begin
        n_fail++;
        $display("FAIL inj_seq%0d: got code=%0d valid=%0b, want code=%0d valid=1", j, CODE_OUT, VALID_OUT, exp_seq[j]);
      end
    end
    step();
    check("inj_idle", outs(), {exp_seq[4], 1'b0, 8'h00, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
